// File: rtl/pid_pkg.sv
// Shared PID definitions: widths, signed limits, FSM states.
// Also used by the controller stage.
package pid_pkg;

   localparam int DW = 32;

   localparam logic signed [DW-1:0] SMAX = 32'sh7FFF_FFFF;
   localparam logic signed [DW-1:0] SMIN = 32'sh8000_0000;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      PRIME = 2'd1,
      RUN   = 2'd2
   } pid_st_e;

   // Clamp a 33-bit signed value into [lo, hi].
   function automatic logic signed [DW-1:0] sat_clip(
      input logic signed [DW:0]   v,
      input logic signed [DW-1:0] lo,
      input logic signed [DW-1:0] hi
   );
      logic signed [DW:0] lo_x;
      logic signed [DW:0] hi_x;
      lo_x = {lo[DW-1], lo};
      hi_x = {hi[DW-1], hi};
      if (v > hi_x)
         return hi;
      else if (v < lo_x)
         return lo;
      else
         return v[DW-1:0];
   endfunction

endpackage

// File: rtl/pid_sat_add.sv
// Signed 32+32 add at 33 bits with a symmetric +/-LIM clamp.
// sat reports that the result sits on either limit.
module pid_sat_add
   import pid_pkg::*;
#(
   parameter logic signed [DW-1:0] LIM = 32'sh3FFF_FFFF
) (
   input  logic signed [DW-1:0] a,
   input  logic signed [DW-1:0] b,
   output logic signed [DW-1:0] y,
   output logic                 sat
);

   logic signed [DW:0]   sum_x;
   logic signed [DW-1:0] lim_n;

   assign lim_n = -LIM;
   assign sum_x = {a[DW-1], a} + {b[DW-1], b};
   assign y     = sat_clip(sum_x, lim_n, LIM);
   assign sat   = (y == LIM) || (y == lim_n);

endmodule

// File: rtl/pid_err_gen.sv
// PID error front end: error, previous error, clamped error sum.
// Optional deadband on the difference via PID_ERR_DEADBAND_EN.
module pid_err_gen
   import pid_pkg::*;
#(
   parameter logic signed [DW-1:0] INT_LIM = 32'sh3FFF_FFFF,
   parameter int                   DB      = 16
) (
   input  logic                 clk,
   input  logic                 rstn,
   input  logic                 en,
   input  logic                 clr,
   input  logic                 hold,
   input  logic                 fb_vld,
   input  logic signed [DW-1:0] setpoint,
   input  logic signed [DW-1:0] feedback,
   output logic signed [DW-1:0] error,
   output logic signed [DW-1:0] error1,
   output logic signed [DW-1:0] sum_e,
   output logic                 err_vld,
   output logic                 sat
);

   pid_st_e st, st_nxt;

   logic                 acc;
   logic                 prime;
   logic signed [DW:0]   diff_x;
   logic signed [DW-1:0] d_sat;
   logic signed [DW-1:0] d;
   logic signed [DW-1:0] sum_add;
   logic                 sum_sat;

   assign acc = en & fb_vld & ~clr;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn)
         st <= IDLE;
      else
         st <= st_nxt;
   end

   always_comb begin
      st_nxt = st;
      if (!en)
         st_nxt = IDLE;
      else if (clr)
         st_nxt = PRIME;
      else begin
         unique case (st)
            IDLE:    st_nxt = acc ? RUN : PRIME;
            PRIME:   st_nxt = acc ? RUN : PRIME;
            RUN:     st_nxt = RUN;
            default: st_nxt = IDLE;
         endcase
      end
   end

   // A sample arriving while still idle is the first after enable.
   always_comb begin
      prime = 1'b1;
      unique case (st)
         RUN:     prime = 1'b0;
         default: prime = 1'b1;
      endcase
   end

   assign diff_x = {setpoint[DW-1], setpoint} - {feedback[DW-1], feedback};
   assign d_sat  = sat_clip(diff_x, SMIN, SMAX);

`ifdef PID_ERR_DEADBAND_EN
   // SMIN lies below -DB, so it always falls outside the deadband.
   assign d = (d_sat >= -DB && d_sat <= DB) ? '0 : d_sat;
`else
   logic unused_db;
   assign unused_db = (DB < 0);
   assign d = d_sat;
`endif

   pid_sat_add #(
      .LIM (INT_LIM)
   ) u_int (
      .a   (sum_e),
      .b   (d),
      .y   (sum_add),
      .sat (sum_sat)
   );

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         error   <= '0;
         error1  <= '0;
         sum_e   <= '0;
         sat     <= 1'b0;
         err_vld <= 1'b0;
      end else begin
         err_vld <= acc;
         if (clr) begin
            error  <= '0;
            error1 <= '0;
            sum_e  <= '0;
            sat    <= 1'b0;
         end else if (acc) begin
            error  <= d;
            error1 <= prime ? d : error;
            if (!hold) begin
               sum_e <= sum_add;
               sat   <= sum_sat;
            end
         end
      end
   end

endmodule

// File: tb/tb_pid_err_gen.sv
// Randomized bench for pid_err_gen against a behavioural model.
// Directed plan vectors first, then random traffic.
module tb_pid_err_gen;

   localparam longint LIM  = 1000;
   localparam int     DBW  = 16;
   localparam longint MAXL = 64'sd2147483647;
   localparam longint MINL = -64'sd2147483648;

   logic               clk;
   logic               rstn;
   logic               en;
   logic               clr;
   logic               hold;
   logic               fb_vld;
   logic signed [31:0] sp;
   logic signed [31:0] fb;
   logic signed [31:0] error;
   logic signed [31:0] error1;
   logic signed [31:0] sum_e;
   logic               err_vld;
   logic               sat;

   int total;
   int bad;

   longint m_err;
   longint m_err1;
   longint m_sum;
   bit     m_sat;
   bit     m_vld;
   bit     m_primed;

   pid_err_gen #(
      .INT_LIM (32'sd1000),
      .DB      (DBW)
   ) dut (
      .clk      (clk),
      .rstn     (rstn),
      .en       (en),
      .clr      (clr),
      .hold     (hold),
      .fb_vld   (fb_vld),
      .setpoint (sp),
      .feedback (fb),
      .error    (error),
      .error1   (error1),
      .sum_e    (sum_e),
      .err_vld  (err_vld),
      .sat      (sat)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0d exp=%0d", tag,
                  $signed(got), $signed(exp));
      end
   endtask

   function automatic longint clip(input longint v, input longint lo,
                                   input longint hi);
      if (v > hi) return hi;
      if (v < lo) return lo;
      return v;
   endfunction

   task automatic model_reset();
      m_err = 0; m_err1 = 0; m_sum = 0;
      m_sat = 0; m_vld = 0; m_primed = 0;
   endtask

   task automatic model_update();
      longint d;
      if (clr) begin
         m_err = 0; m_err1 = 0; m_sum = 0;
         m_sat = 0; m_vld = 0; m_primed = 0;
      end else if (!en) begin
         m_primed = 0;
         m_vld = 0;
      end else if (fb_vld) begin
         d = clip(longint'(sp) - longint'(fb), MINL, MAXL);
`ifdef PID_ERR_DEADBAND_EN
         if (d != MINL && (d < 0 ? -d : d) <= DBW) d = 0;
`endif
         m_err1 = m_primed ? m_err : d;
         m_err = d;
         if (!hold) begin
            m_sum = clip(m_sum + d, -LIM, LIM);
            m_sat = (m_sum == LIM) || (m_sum == -LIM);
         end
         m_primed = 1;
         m_vld = 1;
      end else
         m_vld = 0;
   endtask

   task automatic check_all();
      check("error", error, 32'(m_err));
      check("error1", error1, 32'(m_err1));
      check("sum_e", sum_e, 32'(m_sum));
      check("sat", 32'(sat), 32'(m_sat));
      check("err_vld", 32'(err_vld), 32'(m_vld));
   endtask

   task automatic step();
      @(posedge clk);
      model_update();
      #1;
      check_all();
   endtask

   task automatic drive(input bit e, input bit c, input bit h, input bit v,
                        input int s, input int f);
      en = e; clr = c; hold = h; fb_vld = v;
      sp = s; fb = f;
      step();
   endtask

   initial begin
      total = 0; bad = 0;
      rstn = 1'b0; en = 0; clr = 0; hold = 0; fb_vld = 0;
      sp = 0; fb = 0;
      model_reset();
      #12;
      check_all();
      rstn = 1'b1;

      // priming and run sequence
      drive(1, 0, 0, 1, 100, 40);
      check("prime_err", error, 60);
      check("prime_err1", error1, 60);
      check("prime_sum", sum_e, 60);
      check("prime_vld", 32'(err_vld), 1);
      drive(1, 0, 0, 1, 100, 70);
      check("run_err1", error1, 60);
      check("run_sum", sum_e, 90);
      drive(1, 0, 1, 1, 100, 90);
      check("hold_err", error, 10);
      check("hold_sum", sum_e, 90);
      drive(1, 0, 0, 0, 0, 0);

      // difference saturation
      drive(1, 0, 0, 1, 32'sh7FFF_FFFF, -5);
      check("dsat_hi", error, 32'h7FFF_FFFF);
      drive(1, 0, 0, 1, 32'sh8000_0000, 1);
      check("dsat_lo", error, 32'h8000_0000);

      // integrator clamp
      drive(1, 1, 0, 0, 0, 0);
      for (int i = 0; i < 4; i++) begin
         drive(1, 0, 0, 1, 400, 0);
         check("clamp_sat", 32'(sat), (i >= 2) ? 1 : 0);
      end
      check("clamp_sum", sum_e, 1000);

      // clear priority, then re-prime
      drive(1, 1, 0, 1, 500, 0);
      check("clr_sum", sum_e, 0);
      check("clr_vld", 32'(err_vld), 0);
      drive(1, 0, 0, 1, 70, 20);
      check("reprime", error1, 50);

      // enable gating
      for (int i = 0; i < 3; i++)
         drive(0, 0, 0, 1, 9, 900);
      check("gate_err", error, 50);
      drive(1, 0, 0, 1, 30, 0);
      check("reen_err1", error1, 30);

`ifdef PID_ERR_DEADBAND_EN
      drive(1, 0, 0, 1, 50, 40);
      check("db_in", error, 0);
      drive(1, 0, 0, 1, 50, 30);
      check("db_out", error, 20);
`endif

      // asynchronous reset mid-stream
      drive(1, 0, 0, 1, 300, 0);
      #2 rstn = 1'b0;
      #1;
      model_reset();
      check_all();
      #2 rstn = 1'b1;

      for (int i = 0; i < 2000; i++) begin
         en     = ($urandom_range(0, 15) != 0);
         clr    = ($urandom_range(0, 31) == 0);
         hold   = ($urandom_range(0, 7) == 0);
         fb_vld = ($urandom_range(0, 3) != 0);
         if ($urandom_range(0, 7) == 0) begin
            sp = $urandom;
            fb = $urandom;
         end else begin
            sp = int'($urandom_range(0, 3000)) - 1500;
            fb = int'($urandom_range(0, 3000)) - 1500;
         end
         step();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/pid_err_gen.md
# pid_err_gen

Error-generation front end for the PID controller stage. It samples a setpoint/feedback pair on each feedback strobe and produces the three signed 32-bit operands the controller consumes: current error, previous error, and a clamped error sum. All outputs are registered and carry a one-cycle valid pulse. It also handles first-sample priming, integrator hold and clear, and saturation flagging.

## Interface
- `INT_LIM`, default 32'sh3FFF_FFFF: symmetric integrator clamp; `sum_e` stays in [-INT_LIM, +INT_LIM]. Must be > 0.
- `DB`, default 16: deadband half-width. Used only when `PID_ERR_DEADBAND_EN` is defined.
- `clk`, in, 1: clock.
- `rstn`, in, 1: asynchronous reset, active-low.
- `en`, in, 1: loop enable, level.
- `clr`, in, 1: synchronous clear of all error state, single-cycle.
- `hold`, in, 1: freeze the integrator (anti-windup from downstream), level.
- `fb_vld`, in, 1: sample strobe; `setpoint` and `feedback` are valid this cycle.
- `setpoint`, in, 32 signed: target value.
- `feedback`, in, 32 signed: measured value.
- `error`, out, 32 signed: saturated value of setpoint − feedback.
- `error1`, out, 32 signed: `error` value from the previous accepted sample.
- `sum_e`, out, 32 signed: clamped running sum of `error`.
- `err_vld`, out, 1: one-cycle pulse; the output triple was updated.
- `sat`, out, 1: `sum_e` sits at ±INT_LIM.

## Operation
- **Reset values:** `error`, `error1`, `sum_e` = 0; `err_vld` = 0; `sat` = 0; state = IDLE.
- **FSM states:**
  - IDLE: `en` = 0. Samples are ignored and outputs hold.
  - PRIME: first sample after enable or clear.
  - RUN: normal operation.
- **Transitions:**
  - IDLE→PRIME when `en` = 1.
  - PRIME→RUN on an accepted sample.
  - Any state→IDLE when `en` = 0.
  - `clr` with `en` = 1 → PRIME.
- **Accepted sample:** `en` & `fb_vld` & !`clr`.
- **Difference:** computed at 33 bits as `setpoint` − `feedback`, then saturated to [−2^31, 2^31−1] to give `d`.
- **RUN sample:** `error1` ← `error`; `error` ← `d`; `sum_e` ← clamp(`sum_e` + `d`, ±INT_LIM). The add is done at 33 bits before clamping.
- **PRIME sample:** `error` ← `d`; `error1` ← `d`, so the derivative term is zero on the first sample; `sum_e` ← clamp(`sum_e` + `d`).
- **`hold` = 1:** `sum_e` is unchanged. `error` and `error1` still update.
- **`clr`:** zeroes `error`, `error1`, `sum_e` and `sat`; no `err_vld` is issued. `clr` has priority over a coincident `fb_vld`, and that sample is dropped.
- **`sat`:** registered alongside `sum_e`; high iff the new `sum_e` equals +INT_LIM or −INT_LIM.
- **`en` dropped mid-operation:** outputs keep their last values. Re-enabling re-primes, but `sum_e` is not cleared.

## Timing
- Latency is 1 cycle: a sample accepted at edge N gives updated outputs and `err_vld` = 1 after edge N+1.
- `err_vld` is high for exactly one cycle per accepted sample.
- Back-to-back `fb_vld` every cycle is sustained with no bubbles.
- Outputs are stable between `err_vld` pulses, so the downstream stage may register them on any cycle.
- `en` going low in the same cycle as `fb_vld`: the sample is dropped and `err_vld` stays 0.
- Reset asserted mid-operation: all outputs return to reset values immediately (asynchronous).

## Configuration
- **`PID_ERR_DEADBAND_EN` defined:** after saturation, if |`d`| ≤ DB then `d` is forced to 0. This applies to `error`, `error1` priming, and the integrator. −2^31 is treated as outside the deadband.
- **`PID_ERR_DEADBAND_EN` undefined:** no deadband logic; `DB` is unused.

## Structure
- **Shared package `pid_pkg`:**
  - FSM state enum (IDLE, PRIME, RUN).
  - Data width constant 32.
  - Signed min/max constants for 32 bits.
  - The same package is used by the controller stage.
- **Sub-module `pid_sat_add`:** signed 32+32→33-bit add with symmetric ±LIM clamp and a saturated flag. It is instantiated for the integrator; the difference path uses the same saturation function.

## Test plan
- **Priming:** reset, then `en` = 1, `fb_vld` with setpoint = 100, feedback = 40 → next cycle `error` = 60, `error1` = 60, `sum_e` = 60, `err_vld` = 1.
- **Run sequence:** next sample setpoint = 100, feedback = 70 → `error` = 30, `error1` = 60, `sum_e` = 90. Then `hold` = 1 with feedback = 90 → `error` = 10, `error1` = 30, `sum_e` = 90.
- **Difference saturation:** setpoint = 2^31−1, feedback = −5 → `error` = 2^31−1. Setpoint = −2^31, feedback = 1 → `error` = −2^31.
- **Integrator clamp:** INT_LIM = 1000, repeated error = 400 → `sum_e` = 400, 800, 1000, 1000; `sat` rises with the third sample.
- **Clear priority:** `clr` and `fb_vld` in the same cycle → all three outputs = 0, `err_vld` = 0. The next sample primes (`error1` = `error`).
- **Enable gating and reset:** `en` = 0 with `fb_vld` pulses → no `err_vld`, outputs hold. Deassert `rstn` mid-stream → all outputs 0 asynchronously.
- **Deadband (build with `PID_ERR_DEADBAND_EN`, DB = 16):**
  - setpoint = 50, feedback = 40 → `error` = 0, `sum_e` unchanged.
  - setpoint = 50, feedback = 30 → `error` = 20.
